pin_entry_ctrl: RTL

Keypad-side front end for the combo lock state machine. Collects hex digits from a debounced keypad decoder, assembles them into the 16-bit `pinCode` word, and issues the `trig` pulse the lock samples to evaluate a code. Sits between the keypad scanner and the lock FSM; its `pinCode`/`trig` outputs connect directly to the lock's inputs.

---
 rtl/pin_entry_pkg.sv | 16 +
 rtl/pin_entry_if.sv | 29 ++
 rtl/pin_entry_timer.sv | 35 +++
 rtl/pin_entry_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the keypad PIN entry front end.
package pin_entry_pkg;

   localparam int unsigned NibbleW          = 4;
   localparam int unsigned DefDigits        = 4;
   localparam int unsigned DefTrigCycles    = 3;
   localparam int unsigned DefTimeoutCycles = 1_000_000;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StFire,
      StError
   } state_e;

endpackage

// File: rtl/pin_entry_if.sv
// Keypad strobes in, lock-facing code/trigger and status out.
interface pin_entry_if
   import pin_entry_pkg::*;
#(
   parameter int unsigned DIGITS = DefDigits
);
   localparam int unsigned CntW = $clog2(DIGITS + 1);

   logic [NibbleW-1:0]        key_code;
   logic                      key_valid;
   logic                      key_enter;
   logic                      key_clear;
   logic [NibbleW*DIGITS-1:0] pinCode;
   logic                      trig;
   logic [CntW-1:0]           digit_count;
   logic                      entry_error;
   logic                      busy;

   modport master (
      output key_code, key_valid, key_enter, key_clear,
      input  pinCode, trig, digit_count, entry_error, busy
   );

   modport slave (
      input  key_code, key_valid, key_enter, key_clear,
      output pinCode, trig, digit_count, entry_error, busy
   );

endinterface

// File: rtl/pin_entry_timer.sv
// Loadable down-counter; expired_o is high once Cycles enabled cycles have elapsed after a load.
module pin_entry_timer #(
   parameter int unsigned Cycles = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
   localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LoadVal;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pin_entry_ctrl.sv
// Assembles keypad digits into a PIN word and fires the lock trigger.
// Optional inter-digit timeout is compiled in with PIN_ENTRY_TIMEOUT_EN.
module pin_entry_ctrl
   import pin_entry_pkg::*;
#(
   parameter int unsigned DIGITS         = DefDigits,
   parameter int unsigned TRIG_CYCLES    = DefTrigCycles,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input logic        clk_i,
   input logic        rst_ni,
   pin_entry_if.slave kp
);
   localparam int unsigned CodeW = NibbleW * DIGITS;
   localparam int unsigned CntW  = $clog2(DIGITS + 1);
   localparam logic [CntW-1:0] Full = CntW'(DIGITS);

   state_e           state_q, state_d;
   logic [CodeW-1:0] shift_q, shift_d, pin_q, pin_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             fire_load, fire_done;
   logic             tmo_load, tmo_expired;
   logic             to_error;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      pin_d     = pin_q;
      fire_load = 1'b0;
      tmo_load  = 1'b0;
      to_error  = 1'b0;
      unique case (state_q)
         StIdle, StCollect: begin
            if (kp.key_clear) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end else if (kp.key_enter) begin
               if (cnt_q == Full) begin
                  pin_d     = shift_q;
                  shift_d   = '0;
                  cnt_d     = '0;
                  fire_load = 1'b1;
                  state_d   = StFire;
               end else begin
                  to_error = 1'b1;
               end
            end else if (kp.key_valid) begin
               if (cnt_q < Full) begin
                  shift_d  = (shift_q << NibbleW) | CodeW'(kp.key_code);
                  cnt_d    = cnt_q + CntW'(1);
                  tmo_load = 1'b1;
                  state_d  = StCollect;
               end else begin
                  to_error = 1'b1;
               end
            end else if ((state_q == StCollect) && tmo_expired) begin
               to_error = 1'b1;
            end
         end
         StFire: begin
            if (fire_done) state_d = StIdle;
         end
         StError: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Clear on the way into ERROR so the count already reads 0 during the error pulse.
      if (to_error) begin
         shift_d = '0;
         cnt_d   = '0;
         state_d = StError;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         shift_q <= '0;
         pin_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         pin_q   <= pin_d;
         cnt_q   <= cnt_d;
      end
   end

   pin_entry_timer #(
      .Cycles(TRIG_CYCLES)
   ) u_fire_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (fire_load),
      .en_i     (state_q == StFire),
      .expired_o(fire_done)
   );

`ifdef PIN_ENTRY_TIMEOUT_EN
   pin_entry_timer #(
      .Cycles(TIMEOUT_CYCLES)
   ) u_tmo_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (tmo_load),
      .en_i     (state_q == StCollect),
      .expired_o(tmo_expired)
   );
`else
   localparam int unsigned UnusedTimeout = TIMEOUT_CYCLES;
   logic unused_tmo_load;
   assign unused_tmo_load = tmo_load;
   assign tmo_expired     = 1'b0;
`endif

   assign kp.pinCode     = pin_q;
   assign kp.trig        = (state_q == StFire);
   assign kp.busy        = (state_q == StFire);
   assign kp.digit_count = cnt_q;
   assign kp.entry_error = (state_q == StError);

endmodule
